datain_capture_buf: RTL and testbench



---
 rtl/datain_capture_buf_if.sv | 31 +++
 rtl/datain_capture_buf.sv | 95 +++++++++
 tb/tb_datain_capture_buf.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/datain_capture_buf_if.sv
// Bus bundle for datain_capture_buf: capture inputs, status outputs and the
// random-access readout port. The master side drives flits and read requests.
interface datain_capture_buf_if #(
  parameter int FLIT_W      = 20,
  parameter int PAYLOAD_LSB = 4,
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = $clog2(DEPTH)
);
  logic                          clear;
  logic                          in_valid;
  logic [FLIT_W-1:0]             datain;
  logic                          state;
  logic [FLIT_W-PAYLOAD_LSB-1:0] read;
  logic [ADDR_W:0]               count;
  logic [ADDR_W-1:0]             wr_ptr;
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic [FLIT_W-1:0]             rd_data;
  logic                          rd_valid;
  logic [15:0]                   drop_cnt;

  modport master (
    output clear, in_valid, datain, rd_en, rd_addr,
    input  state, read, count, wr_ptr, rd_data, rd_valid, drop_cnt
  );

  modport slave (
    input  clear, in_valid, datain, rd_en, rd_addr,
    output state, read, count, wr_ptr, rd_data, rd_valid, drop_cnt
  );
endinterface

// File: rtl/datain_capture_buf.sv
// Ejection-port flit capture buffer with ring/stop modes and registered readout.
// Optional DATAIN_CAPTURE_BUF_DROP_CNT_EN enables the saturating drop counter.
module datain_capture_buf #(
  parameter int FLIT_W      = 20,
  parameter int PAYLOAD_LSB = 4,
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter bit RING        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  datain_capture_buf_if.slave  bus
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              state_q, state_d;
  logic [FLIT_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              accept;

  // rst and clear both swallow a coincident flit: not stored, not dropped.
  always_comb begin
    accept   = bus.in_valid && !rst && !bus.clear && (RING || count_q != FULL);
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
      state_d  = 1'b0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != FULL)         count_d = count_q + 1'b1;
      if (count_q == FULL - 1'b1)  state_d = 1'b1;
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = bus.rd_en ? mem[bus.rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Memory is never reset; the readout above samples it before this write lands.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= bus.datain;
  end

`ifdef DATAIN_CAPTURE_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.clear)
      drop_cnt_d = '0;
    else if (bus.in_valid && !accept && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.read     = bus.datain[FLIT_W-1:PAYLOAD_LSB];
  assign bus.state    = state_q;
  assign bus.count    = count_q;
  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_datain_capture_buf.sv
// Drives one stimulus stream into a stop-mode and a ring-mode buffer and checks
// both against a reference built on "flits accepted since reset/clear".
module tb_datain_capture_buf;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, rd_en;
  logic [19:0] datain;
  logic [6:0]  rd_addr;

  int vectors = 0;
  int miscompares = 0;

  // Reference state, index 0 = stop mode, 1 = ring mode.
  int          n     [2];
  int          drops [2];
  logic [19:0] mm    [2][DEPTH];
  bit          kn    [2][DEPTH];
  logic [19:0] rdd   [2];
  bit          rdv   [2];
  bit          rdk   [2];

  always #5 clk = ~clk;

  datain_capture_buf_if #(.FLIT_W(20), .PAYLOAD_LSB(4), .DEPTH(DEPTH)) if_s ();
  datain_capture_buf_if #(.FLIT_W(20), .PAYLOAD_LSB(4), .DEPTH(DEPTH)) if_r ();

  assign if_s.clear = clear;  assign if_r.clear = clear;
  assign if_s.in_valid = in_valid;  assign if_r.in_valid = in_valid;
  assign if_s.datain = datain;  assign if_r.datain = datain;
  assign if_s.rd_en = rd_en;  assign if_r.rd_en = rd_en;
  assign if_s.rd_addr = rd_addr;  assign if_r.rd_addr = rd_addr;

  datain_capture_buf #(.FLIT_W(20), .PAYLOAD_LSB(4), .DEPTH(DEPTH), .RING(1'b0)) u_stop (
    .clk(clk), .rst(rst), .bus(if_s.slave));
  datain_capture_buf #(.FLIT_W(20), .PAYLOAD_LSB(4), .DEPTH(DEPTH), .RING(1'b1)) u_ring (
    .clk(clk), .rst(rst), .bus(if_r.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mode(input int m, input logic [31:0] cnt, input logic [31:0] st,
                            input logic [31:0] wp, input logic [31:0] rv,
                            input logic [31:0] rdat, input logic [31:0] dc);
    int exp_drop;
    string pfx;
    pfx = (m == 1) ? "ring" : "stop";
`ifdef DATAIN_CAPTURE_BUF_DROP_CNT_EN
    exp_drop = drops[m];
`else
    exp_drop = 0;
`endif
    chk({pfx, ".count"},    cnt, 32'((n[m] < DEPTH) ? n[m] : DEPTH));
    chk({pfx, ".state"},    st,  32'(n[m] >= DEPTH));
    chk({pfx, ".wr_ptr"},   wp,  32'(n[m] % DEPTH));
    chk({pfx, ".rd_valid"}, rv,  32'(rdv[m]));
    chk({pfx, ".drop_cnt"}, dc,  32'(exp_drop));
    if (rdk[m]) chk({pfx, ".rd_data"}, rdat, 32'(rdd[m]));
  endtask

  // One clock: check the combinational payload, advance the reference on the
  // edge using the inputs the DUT sampled, then check registered outputs.
  task automatic cycle();
    #1;
    chk("stop.read", 32'(if_s.read), 32'(datain >> 4));
    chk("ring.read", 32'(if_r.read), 32'(datain >> 4));
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        rdd[m] = '0; rdv[m] = 1'b0; rdk[m] = 1'b1;
      end else if (rd_en) begin
        rdd[m] = mm[m][rd_addr]; rdv[m] = 1'b1; rdk[m] = kn[m][rd_addr];
      end else begin
        rdv[m] = 1'b0;
      end
      if (rst || clear) begin
        n[m] = 0; drops[m] = 0;
      end else if (in_valid) begin
        if (m == 1 || n[m] < DEPTH) begin
          mm[m][n[m] % DEPTH] = datain;
          kn[m][n[m] % DEPTH] = 1'b1;
          n[m]++;
        end else if (drops[m] < 65535) begin
          drops[m]++;
        end
      end
    end
    #1;
    check_mode(0, 32'(if_s.count), 32'(if_s.state), 32'(if_s.wr_ptr),
               32'(if_s.rd_valid), 32'(if_s.rd_data), 32'(if_s.drop_cnt));
    check_mode(1, 32'(if_r.count), 32'(if_r.state), 32'(if_r.wr_ptr),
               32'(if_r.rd_valid), 32'(if_r.rd_data), 32'(if_r.drop_cnt));
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      n[m] = 0; drops[m] = 0; rdd[m] = '0; rdv[m] = 1'b0; rdk[m] = 1'b0;
    end
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; rd_en = 1'b0; rd_addr = '0;
    datain = 20'($urandom);

    // Reset held two cycles with valid flits that must be ignored.
    cycle();
    datain = 20'($urandom);
    cycle();
    rst = 1'b0;

    // Fill 128 entries then two more (ring overwrites 0/1, stop drops them).
    for (int i = 0; i < 130; i++) begin
      in_valid = 1'b1;
      datain   = 20'(i << 4);
      rd_en    = 1'($urandom);
      rd_addr  = 7'($urandom);
      cycle();
    end

    in_valid = 1'b0; rd_en = 1'b1; rd_addr = 7'd5;
    cycle();
    chk("stop.rd_addr5", 32'(if_s.rd_data), 32'(5 << 4));
    chk("ring.rd_addr5", 32'(if_r.rd_data), 32'(5 << 4));

    // Advance ring pointer to 5, then read 5 while writing it.
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; datain = 20'($urandom);
      cycle();
    end
    in_valid = 1'b1; datain = 20'hFEED0; rd_en = 1'b1; rd_addr = 7'd5;
    cycle();
    chk("ring.rbw_old", 32'(if_r.rd_data), 32'(5 << 4));
    in_valid = 1'b0;
    cycle();
    chk("ring.rbw_new", 32'(if_r.rd_data), 32'h0FEED0);

    // Payload passthrough with no valid flit.
    rd_en = 1'b0; datain = 20'hABCD7;
    #1;
    chk("passthru", 32'(if_r.read), 32'h0000ABCD);
    cycle();

    // Clear, ten writes, clear together with a flit, one more write.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; datain = 20'($urandom);
      cycle();
    end
    clear = 1'b1; in_valid = 1'b1; datain = 20'h12345;
    cycle();
    clear = 1'b0; datain = 20'h54321;
    cycle();
    in_valid = 1'b0; rd_en = 1'b1; rd_addr = 7'd0;
    cycle();
    chk("clear.addr0", 32'(if_s.rd_data), 32'h54321);
    rd_addr = 7'd9;
    cycle();

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      clear    = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      datain   = 20'($urandom);
      rd_en    = 1'($urandom);
      rd_addr  = 7'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
